// File: rtl/demux_router_pkg.sv
// Shared types for the 1-to-4 stream router: channel count, destination type, slot state.
package demux_router_pkg;
   localparam int NUM_CH = 4;
   localparam int DEST_W = 2;

   typedef logic [DEST_W-1:0] dest_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;
endpackage

// File: rtl/demux_router_slot.sv
// One-entry output holding slot with valid flag and a saturating drain counter.
// The counter is only built when DEMUX_ROUTER_STATS_EN is defined; otherwise cnt is tied to zero.
module demux_router_slot
   import demux_router_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              rdy,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              loadable,
   output logic [CNT_W-1:0]  cnt
);
   slot_state_e       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              drain;

   always_comb begin
      drain    = (state_q == SLOT_FULL) && rdy;
      loadable = (state_q == SLOT_EMPTY) || rdy;
      state_d  = state_q;
      data_d   = data_q;
      // A reload wins over the drain so the slot stays FULL with the new word.
      if (load) begin
         state_d = SLOT_FULL;
         data_d  = ld_data;
      end else if (drain) begin
         state_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign valid = (state_q == SLOT_FULL);
   assign data  = data_q;

`ifdef DEMUX_ROUTER_STATS_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (drain && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
`else
   assign cnt = '0;
`endif
endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-4 valid/ready stream router; each channel has its own one-entry slot.
// Optional per-channel drain counters are enabled by defining DEMUX_ROUTER_STATS_EN.
module demux_stream_router
   import demux_router_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [DEST_W-1:0]        in_dest,
   output logic                     in_ready,
   output logic [NUM_CH-1:0]        out_valid,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*CNT_W-1:0]  stat_cnt
);
   logic [NUM_CH-1:0] loadable;
   logic [NUM_CH-1:0] load;

   // in_ready must not depend on in_valid, so it is a pure mux of slot status.
   assign in_ready = loadable[in_dest];

   always_comb begin
      load = '0;
      for (int k = 0; k < NUM_CH; k++)
         load[k] = in_valid && in_ready && (in_dest == dest_t'(k));
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_router_slot #(
         .DATA_W(DATA_W),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (load[k]),
         .ld_data (in_data),
         .rdy     (out_ready[k]),
         .valid   (out_valid[k]),
         .data    (out_data[k*DATA_W +: DATA_W]),
         .loadable(loadable[k]),
         .cnt     (stat_cnt[k*CNT_W +: CNT_W])
      );
   end
endmodule
